// File: rtl/conv_ddr_pkg.sv
// conv_ddr_pkg: loader indices, outstanding-read tag type and read arbiter state encoding
// shared by the conv DDR read path.
package conv_ddr_pkg;

   localparam int LD_INPUT  = 0;
   localparam int LD_WEIGHT = 1;
   localparam int LD_BIAS   = 2;

   // Tag field widths must match the arbiter's REQ_NUM index width and LEN_W.
   localparam int TAG_IDX_W = 2;
   localparam int TAG_LEN_W = 16;

   typedef struct packed {
      logic [TAG_IDX_W-1:0] idx;
      logic [TAG_LEN_W-1:0] len;
   } ddr_rd_tag_t;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_CMD  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ddr_rd_tag_fifo.sv
// ddr_rd_tag_fifo: synchronous first-word-fall-through FIFO holding the owner/length tag
// of every DDR read command still waiting for its data.
module ddr_rd_tag_fifo #(
   parameter int W          = 18,
   parameter int DEPTH_2POW = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                push,
   input  logic [W-1:0]        push_data,
   input  logic                pop,
   output logic [W-1:0]        head,
   output logic                full,
   output logic                empty,
   output logic [DEPTH_2POW:0] count
);

   localparam int DEPTH = 1 << DEPTH_2POW;
   localparam logic [DEPTH_2POW-1:0] PTR_ONE = {{(DEPTH_2POW-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_2POW:0]   CNT_ONE = {{DEPTH_2POW{1'b0}}, 1'b1};
   localparam logic [DEPTH_2POW:0]   CNT_MAX = (DEPTH_2POW+1)'(DEPTH);

   logic [W-1:0]            mem_q [DEPTH];
   logic [DEPTH_2POW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_2POW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_2POW:0]     count_q, count_d;
   logic                    do_push_s;
   logic                    do_pop_s;

   assign full      = (count_q == CNT_MAX);
   assign empty     = (count_q == {(DEPTH_2POW+1){1'b0}});
   assign count     = count_q;
   assign head      = mem_q[rd_ptr_q];
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;

   // Pointer and occupancy next-state; simultaneous push and pop leave the count unchanged.
   always_comb begin
      wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Tag storage; contents are only observed while count_q is non-zero.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: shares the DDR read command/data port among the conv loaders and routes
// returned beats to their owner. Define DDR_RD_ARB_RR_EN for round-robin grants.
module ddr_rd_arbiter
   import conv_ddr_pkg::*;
#(
   parameter int REQ_NUM        = 3,
   parameter int ADR_W          = 32,
   parameter int LEN_W          = 16,
   parameter int DATA_W         = 512,
   parameter int TAG_DEPTH_2POW = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [REQ_NUM-1:0]          req_valid,
   input  logic [REQ_NUM*ADR_W-1:0]    req_adr,
   input  logic [REQ_NUM*LEN_W-1:0]    req_len,
   output logic [REQ_NUM-1:0]          req_ready,
   output logic                        ddr_cmd_valid,
   input  logic                        ddr_cmd_ready,
   output logic [ADR_W-1:0]            ddr_cmd_adr,
   output logic [LEN_W-1:0]            ddr_cmd_len,
   input  logic                        ddr_rd_data_valid,
   input  logic [DATA_W-1:0]           ddr_rd_data,
   output logic [REQ_NUM-1:0]          rd_valid_out,
   output logic [DATA_W-1:0]           rd_data_out,
   output logic [TAG_DEPTH_2POW:0]     outstanding,
   output logic                        err_orphan
);

   localparam int IDX_W = TAG_IDX_W;
   localparam logic [REQ_NUM-1:0] REQ_ONE = {{(REQ_NUM-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0]   LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   arb_state_t              state_q, state_d;
   logic [REQ_NUM-1:0]      req_ready_q, req_ready_d;
   logic                    cmd_valid_q, cmd_valid_d;
   logic [ADR_W-1:0]        cmd_adr_q, cmd_adr_d;
   logic [LEN_W-1:0]        cmd_len_q, cmd_len_d;
   logic [IDX_W-1:0]        cmd_idx_q, cmd_idx_d;
   logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;
   logic [REQ_NUM-1:0]      rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]       rd_data_q, rd_data_d;
   logic                    err_orphan_q, err_orphan_d;

   logic                    grant_vld_s;
   logic [IDX_W-1:0]        grant_idx_s;
   logic                    grant_fire_s;
   logic [LEN_W-1:0]        grant_len_s;
   logic [LEN_W-1:0]        remain_s;
   logic                    push_s;
   logic                    pop_s;
   ddr_rd_tag_t             push_tag_s;
   ddr_rd_tag_t             head_s;
   logic                    full_s;
   logic                    empty_s;

   assign req_ready     = req_ready_q;
   assign ddr_cmd_valid = cmd_valid_q;
   assign ddr_cmd_adr   = cmd_adr_q;
   assign ddr_cmd_len   = cmd_len_q;
   assign rd_valid_out  = rd_valid_q;
   assign rd_data_out   = rd_data_q;
   assign err_orphan    = err_orphan_q;

   // No grant while the previous pulse is still visible, so a held req_valid is not taken twice.
   assign grant_fire_s = (state_q == ARB_IDLE) && grant_vld_s && !full_s
                         && (req_ready_q == {REQ_NUM{1'b0}});
   assign grant_len_s  = req_len[grant_idx_s*LEN_W +: LEN_W];

`ifdef DDR_RD_ARB_RR_EN
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] rr_cand_s;

   // Rotated search from rr_ptr_q; scanning downward lets the nearest requester win.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_idx_s = '0;
      rr_cand_s   = '0;
      for (int k = REQ_NUM - 1; k >= 0; k--) begin
         rr_cand_s = IDX_W'((int'(rr_ptr_q) + k) % REQ_NUM);
         if (req_valid[rr_cand_s]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = rr_cand_s;
         end else begin
            grant_vld_s = grant_vld_s;
            grant_idx_s = grant_idx_s;
         end
      end
   end

   // Pointer moves past every granted index, zero-length grants included.
   always_comb begin
      if (!grant_fire_s) begin
         rr_ptr_d = rr_ptr_q;
      end else if (grant_idx_s == IDX_W'(REQ_NUM - 1)) begin
         rr_ptr_d = '0;
      end else begin
         rr_ptr_d = grant_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   // Fixed priority: downward scan leaves the lowest requesting index.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_idx_s = '0;
      for (int k = REQ_NUM - 1; k >= 0; k--) begin
         if (req_valid[k]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = IDX_W'(k);
         end else begin
            grant_vld_s = grant_vld_s;
            grant_idx_s = grant_idx_s;
         end
      end
   end
`endif

   // Command FSM next-state: grant in IDLE, hold the command in CMD until DDR accepts it.
   always_comb begin
      state_d     = state_q;
      req_ready_d = '0;
      cmd_valid_d = cmd_valid_q;
      cmd_adr_d   = cmd_adr_q;
      cmd_len_d   = cmd_len_q;
      cmd_idx_d   = cmd_idx_q;
      push_s      = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (grant_fire_s) begin
               req_ready_d = REQ_ONE << grant_idx_s;
               cmd_adr_d   = req_adr[grant_idx_s*ADR_W +: ADR_W];
               cmd_len_d   = grant_len_s;
               cmd_idx_d   = grant_idx_s;
               if (grant_len_s != {LEN_W{1'b0}}) begin
                  state_d     = ARB_CMD;
                  cmd_valid_d = 1'b1;
               end else begin
                  state_d     = ARB_IDLE;
                  cmd_valid_d = 1'b0;
               end
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_CMD: begin
            if (ddr_cmd_ready) begin
               push_s      = 1'b1;
               cmd_valid_d = 1'b0;
               state_d     = ARB_IDLE;
            end else begin
               state_d = ARB_CMD;
            end
         end
         default: begin
            state_d     = ARB_IDLE;
            cmd_valid_d = 1'b0;
         end
      endcase
   end

   assign push_tag_s.idx = cmd_idx_q;
   assign push_tag_s.len = TAG_LEN_W'(cmd_len_q);

   // Return path: route each beat to the head tag's owner and pop on its last beat.
   always_comb begin
      rd_valid_d   = '0;
      rd_data_d    = '0;
      beat_cnt_d   = beat_cnt_q;
      err_orphan_d = err_orphan_q;
      pop_s        = 1'b0;
      remain_s     = (beat_cnt_q == {LEN_W{1'b0}}) ? LEN_W'(head_s.len) : beat_cnt_q;
      if (ddr_rd_data_valid) begin
         if (!empty_s) begin
            rd_valid_d = REQ_ONE << head_s.idx;
            rd_data_d  = ddr_rd_data;
            if (remain_s == LEN_ONE) begin
               pop_s      = 1'b1;
               beat_cnt_d = '0;
            end else begin
               beat_cnt_d = remain_s - LEN_ONE;
            end
         end else begin
            err_orphan_d = 1'b1;
         end
      end else begin
         beat_cnt_d = beat_cnt_q;
      end
   end

   // Command FSM and command output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         req_ready_q <= '0;
         cmd_valid_q <= 1'b0;
         cmd_adr_q   <= '0;
         cmd_len_q   <= '0;
         cmd_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_adr_q   <= cmd_adr_d;
         cmd_len_q   <= cmd_len_d;
         cmd_idx_q   <= cmd_idx_d;
      end
   end

   // Return path registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         beat_cnt_q   <= '0;
         rd_valid_q   <= '0;
         rd_data_q    <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         beat_cnt_q   <= beat_cnt_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   ddr_rd_tag_fifo #(
      .W          ($bits(ddr_rd_tag_t)),
      .DEPTH_2POW (TAG_DEPTH_2POW)
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (push_tag_s),
      .pop       (pop_s),
      .head      (head_s),
      .full      (full_s),
      .empty     (empty_s),
      .count     (outstanding)
   );

endmodule
